// File: rtl/alarm_buzzer_scheduler.sv
// alarm_buzzer_scheduler
// Shares one buzzer pin among three alarm channels. Requests are latched as
// pending, served round-robin, and each grant produces a fixed-length tone
// burst (per-channel pattern) followed by a silent gap. Every output is a
// register so downstream pin logic sees glitch-free levels.
//
// Handshake: req carries no valid/ready pair. A request is accepted on any
// clock edge where req[i]=1, in every state and regardless of enable, and it
// sits in pending[i] until the scheduler grants that channel. There is no
// backpressure; repeated requests for an already pending channel merge.

module alarm_buzzer_scheduler #(
    parameter int ON_CYCLES  = 32,
    parameter int GAP_CYCLES = 8,
    parameter int TONE_DIV   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic [2:0] req,
    output logic [2:0] grant,
    output logic [2:0] pending,
    output logic       busy,
    output logic [2:0] done,
    output logic       buzzer_out
);

    // Timer only has to count to the longer of the two timed states.
    localparam int MAX_CYCLES = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int TW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;

    localparam logic [TW-1:0] ON_LAST  = TW'(ON_CYCLES - 1);
    localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SOUND = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    // Channel of the most recent grant; during SOUND it is also the channel
    // currently sounding, so no separate "current channel" register is kept.
    logic [1:0]    last_grant;

    logic [1:0]    rr_start;
    logic [1:0]    sel;
    logic [2:0]    sel_onehot;
    logic [2:0]    cur_onehot;
    logic [TW-1:0] next_phase;

    // Convert a channel index to its one-hot grant/done vector.
    function automatic logic [2:0] to_onehot(input logic [1:0] ch);
        logic [2:0] v;
        v = 3'b000;
        case (ch)
            2'd0:    v = 3'b001;
            2'd1:    v = 3'b010;
            2'd2:    v = 3'b100;
            default: v = 3'b000;
        endcase
        return v;
    endfunction

    // First set bit of vec, scanning upward from start with wrap at 3.
    function automatic logic [1:0] rr_pick(input logic [1:0] start,
                                           input logic [2:0] vec);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        idx   = start;
        pick  = start;
        found = 1'b0;
        for (int n = 0; n < 3; n++) begin
            if (!found && vec[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
            idx = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end
        return pick;
    endfunction

    // Tone level for a channel at a given burst phase. The phase is cut into
    // TONE_DIV-cycle slots k: ch0 is steady, ch1 toggles every slot, ch2 is on
    // for one slot out of every four.
    function automatic logic tone_bit(input logic [1:0]    ch,
                                      input logic [TW-1:0] phase);
        logic [31:0] k;
        logic        b;
        k = 32'(phase) / 32'(TONE_DIV);
        case (ch)
            2'd0:    b = 1'b1;
            2'd1:    b = (k[0] == 1'b0);
            2'd2:    b = (k[1:0] == 2'b00);
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    // Round-robin arbitration: start one past the last served channel.
    always_comb begin
        rr_start   = (last_grant == 2'd2) ? 2'd0 : last_grant + 2'd1;
        sel        = rr_pick(rr_start, pending);
        sel_onehot = to_onehot(sel);
        cur_onehot = to_onehot(last_grant);
        next_phase = timer + TW'(1);
    end

    // Scheduler FSM together with the pending latch; all outputs registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            timer      <= '0;
            last_grant <= 2'd2;
            grant      <= 3'b000;
            pending    <= 3'b000;
            done       <= 3'b000;
            busy       <= 1'b0;
            buzzer_out <= 1'b0;
        end else begin
            // done is a single-cycle pulse; only the burst-complete branch
            // raises it.
            done    <= 3'b000;
            // New requests always latch; branches below add clears or re-sets.
            pending <= pending | req;

            case (state)
                IDLE: begin
                    buzzer_out <= 1'b0;
                    grant      <= 3'b000;
                    if (enable && (pending != 3'b000)) begin
                        state      <= SOUND;
                        busy       <= 1'b1;
                        grant      <= sel_onehot;
                        last_grant <= sel;
                        timer      <= '0;
                        buzzer_out <= tone_bit(sel, '0);
                        // Same-cycle request for the granted channel survives.
                        pending    <= (pending & ~sel_onehot) | req;
                    end else begin
                        busy <= 1'b0;
                    end
                end

                SOUND: begin
                    if (!enable) begin
                        // Aborted burst: silence now, re-queue the channel so
                        // it replays in full once enabled again.
                        state      <= GAP;
                        grant      <= 3'b000;
                        buzzer_out <= 1'b0;
                        timer      <= '0;
                        pending    <= pending | req | cur_onehot;
                    end else if (timer == ON_LAST) begin
                        state      <= GAP;
                        grant      <= 3'b000;
                        buzzer_out <= 1'b0;
                        timer      <= '0;
                        done       <= cur_onehot;
                    end else begin
                        timer      <= next_phase;
                        buzzer_out <= tone_bit(last_grant, next_phase);
                    end
                end

                GAP: begin
                    buzzer_out <= 1'b0;
                    grant      <= 3'b000;
                    if (timer == GAP_LAST) begin
                        // Always return through IDLE before the next grant.
                        state <= IDLE;
                        busy  <= 1'b0;
                        timer <= '0;
                    end else begin
                        timer <= next_phase;
                    end
                end

                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    grant      <= 3'b000;
                    buzzer_out <= 1'b0;
                    timer      <= '0;
                end
            endcase
        end
    end

    // Structural invariants of the registered outputs.
    grant_onehot_a : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(grant));
    done_onehot_a : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(done));
    busy_state_a : assert property (@(posedge clk) disable iff (!rst_n)
        busy == (state != IDLE));
    quiet_outside_sound_a : assert property (@(posedge clk) disable iff (!rst_n)
        (state != SOUND) |-> (!buzzer_out && grant == 3'b000));

endmodule

// File: tb/tb_alarm_buzzer_scheduler.sv
// Bench for alarm_buzzer_scheduler: each scenario task builds an expected
// per-cycle trace from the behavioural description, drives requests/enable
// cycle by cycle and compares every registered output after each edge.

module tb_alarm_buzzer_scheduler;

    localparam int ON_CYCLES  = 32;
    localparam int GAP_CYCLES = 8;
    localparam int TONE_DIV   = 4;

    // Clock / reset
    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [2:0] req;
    logic [2:0] grant;
    logic [2:0] pending;
    logic       busy;
    logic [2:0] done;
    logic       buzzer_out;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    alarm_buzzer_scheduler #(
        .ON_CYCLES (ON_CYCLES),
        .GAP_CYCLES(GAP_CYCLES),
        .TONE_DIV  (TONE_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .req       (req),
        .grant     (grant),
        .pending   (pending),
        .busy      (busy),
        .done      (done),
        .buzzer_out(buzzer_out)
    );

    // Scoreboard: entry = {grant, buzzer, done, busy, pending, pending_care}
    logic [13:0] exp_q[$];
    int          n_checks;
    int          n_fail;

    // Expected tone straight from the pattern strings:
    // ch0 all ones, ch1 "11110000", ch2 "1111000000000000".
    function automatic logic tone_ref(input int ch, input int p);
        if (ch == 0) return 1'b1;
        if (ch == 1) return ((p % 8) < 4);
        return ((p % 16) < 4);
    endfunction

    function automatic logic [2:0] oh(input int ch);
        logic [2:0] v;
        v = 3'b000;
        v[ch] = 1'b1;
        return v;
    endfunction

    // Driver / trace-builder tasks
    task automatic push_idle(input int n, input logic [2:0] pend,
                             input logic [2:0] care = 3'b111);
        for (int i = 0; i < n; i++)
            exp_q.push_back({3'b000, 1'b0, 3'b000, 1'b0, pend, care});
    endtask

    task automatic push_sound(input int ch, input int n, input logic [2:0] pend,
                              input logic [2:0] care = 3'b111);
        for (int p = 0; p < n; p++)
            exp_q.push_back({oh(ch), tone_ref(ch, p), 3'b000, 1'b1, pend, care});
    endtask

    task automatic push_gap(input logic [2:0] dn, input logic [2:0] pend,
                            input logic [2:0] care = 3'b111);
        for (int g = 0; g < GAP_CYCLES; g++)
            exp_q.push_back({3'b000, 1'b0, (g == 0) ? dn : 3'b000, 1'b1, pend, care});
    endtask

    task automatic push_burst(input int ch, input logic [2:0] pend,
                              input logic [2:0] care = 3'b111);
        push_sound(ch, ON_CYCLES, pend, care);
        push_gap(oh(ch), pend, care);
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        req    = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        enable = 1'b1;
        req    = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (grant !== 3'b000) begin n_fail++; $display("FAIL reset_grant act=%b exp=000", grant); end
        n_checks++; if (pending !== 3'b000) begin n_fail++; $display("FAIL reset_pending act=%b exp=000", pending); end
        n_checks++; if (done !== 3'b000) begin n_fail++; $display("FAIL reset_done act=%b exp=000", done); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy act=%b exp=0", busy); end
        n_checks++; if (buzzer_out !== 1'b0) begin n_fail++; $display("FAIL reset_buzzer act=%b exp=0", buzzer_out); end
        rst_n = 1'b1;
        req   = 3'b000;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_checks++;
            if ({grant, busy, pending} !== 7'b0) begin
                n_fail++;
                $display("FAIL reset_idle cyc=%0d act=%b exp=0000000", i, {grant, busy, pending});
            end
        end
    endtask

    task automatic test_single();
        logic [10:0] act;
        logic [13:0] e;
        do_reset();
        push_idle(1, 3'b001);
        push_burst(0, 3'b000);
        push_idle(2, 3'b000);
        for (int i = 0; exp_q.size() > 0; i++) begin
            req = (i == 0) ? 3'b001 : 3'b000;
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            act = {grant, buzzer_out, done, busy, pending};
            n_checks++;
            if (((act ^ e[13:3]) & {8'hFF, e[2:0]}) != 11'd0) begin
                n_fail++;
                $display("FAIL single cyc=%0d act=%b exp=%b", i, act, e[13:3]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [10:0] act;
        logic [13:0] e;
        do_reset();
        push_idle(1, 3'b111);
        push_burst(0, 3'b110);
        push_idle(1, 3'b110);
        push_burst(1, 3'b100);
        push_idle(1, 3'b100);
        push_burst(2, 3'b000);
        push_idle(2, 3'b000);
        for (int i = 0; exp_q.size() > 0; i++) begin
            req = (i == 0) ? 3'b111 : 3'b000;
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            act = {grant, buzzer_out, done, busy, pending};
            n_checks++;
            if (((act ^ e[13:3]) & {8'hFF, e[2:0]}) != 11'd0) begin
                n_fail++;
                $display("FAIL back_to_back cyc=%0d act=%b exp=%b", i, act, e[13:3]);
            end
        end
    endtask

    task automatic test_fairness();
        logic [10:0] act;
        logic [13:0] e;
        do_reset();
        push_idle(1, 3'b001);
        push_sound(0, ON_CYCLES, 3'b001, 3'b101);
        push_gap(3'b001, 3'b011);
        push_idle(1, 3'b011);
        push_burst(1, 3'b001);
        push_idle(1, 3'b001);
        push_sound(0, 4, 3'b001);
        for (int i = 0; exp_q.size() > 0; i++) begin
            req = 3'b001 | ((i == 6) ? 3'b010 : 3'b000);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            act = {grant, buzzer_out, done, busy, pending};
            n_checks++;
            if (((act ^ e[13:3]) & {8'hFF, e[2:0]}) != 11'd0) begin
                n_fail++;
                $display("FAIL fairness cyc=%0d act=%b exp=%b", i, act, e[13:3]);
            end
        end
        req = 3'b000;
    endtask

    task automatic test_tones();
        logic [10:0] act;
        logic [13:0] e;
        for (int ch = 0; ch < 3; ch++) begin
            do_reset();
            push_idle(1, oh(ch));
            push_burst(ch, 3'b000);
            push_idle(1, 3'b000);
            for (int i = 0; exp_q.size() > 0; i++) begin
                req = (i == 0) ? oh(ch) : 3'b000;
                @(posedge clk); #1;
                e   = exp_q.pop_front();
                act = {grant, buzzer_out, done, busy, pending};
                n_checks++;
                if (((act ^ e[13:3]) & {8'hFF, e[2:0]}) != 11'd0) begin
                    n_fail++;
                    $display("FAIL tone_ch%0d cyc=%0d act=%b exp=%b", ch, i, act, e[13:3]);
                end
            end
        end
    endtask

    task automatic test_enable_abort();
        logic [10:0] act;
        logic [13:0] e;
        do_reset();
        push_idle(1, 3'b100);
        push_sound(2, 11, 3'b000);      // phases 0..10
        push_gap(3'b000, 3'b100);       // aborted: no done, pending re-set
        push_idle(10, 3'b100);          // held in IDLE while disabled
        push_burst(2, 3'b000);          // full replay
        push_idle(2, 3'b000);
        for (int i = 0; exp_q.size() > 0; i++) begin
            req    = (i == 0) ? 3'b100 : 3'b000;
            enable = !(i >= 12 && i <= 29);
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            act = {grant, buzzer_out, done, busy, pending};
            n_checks++;
            if (((act ^ e[13:3]) & {8'hFF, e[2:0]}) != 11'd0) begin
                n_fail++;
                $display("FAIL enable_abort cyc=%0d act=%b exp=%b", i, act, e[13:3]);
            end
        end
        enable = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic [10:0] act;
        logic [13:0] e;
        do_reset();
        push_idle(1, 3'b011);
        push_sound(0, 6, 3'b010);       // phases 0..5
        push_idle(45, 3'b000);          // reset edge, then nothing granted
        for (int i = 0; exp_q.size() > 0; i++) begin
            req   = (i == 0) ? 3'b011 : 3'b000;
            rst_n = (i == 7) ? 1'b0 : 1'b1;
            @(posedge clk); #1;
            e   = exp_q.pop_front();
            act = {grant, buzzer_out, done, busy, pending};
            n_checks++;
            if (((act ^ e[13:3]) & {8'hFF, e[2:0]}) != 11'd0) begin
                n_fail++;
                $display("FAIL reset_mid cyc=%0d act=%b exp=%b", i, act, e[13:3]);
            end
        end
        rst_n = 1'b1;
    endtask

    // Sequence and final report
    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        enable   = 1'b0;
        req      = 3'b000;
        test_reset();
        test_single();
        test_back_to_back();
        test_fairness();
        test_tones();
        test_enable_abort();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
